// File: rtl/ppu_shadow_regs.sv
// Double-buffered PPU control-register bank: CPU writes shadow copies, active copies update at vblank.
// Optional saturating abandoned-commit counter enabled by PPU_SHADOW_MISS_CNT_EN.
module ppu_shadow_regs #(
    parameter int unsigned          NUM_REGS  = 4,
    parameter int unsigned          DATA_W    = 32,
    parameter int unsigned          ADDR_W    = 2,
    parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic [DATA_W/8-1:0]          wr_byteena,
    input  logic                         cpu_wr_busy,
    input  logic                         vblank_start,
    input  logic                         vblank_end_soon,
    output logic [NUM_REGS*DATA_W-1:0]   active_regs,
    output logic                         pending,
    output logic                         commit_done,
    output logic [7:0]                   commit_miss_cnt
);

    localparam int unsigned NUM_BYTES = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIRTY = 2'd1,
        DEFER = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [DATA_W-1:0]   shadow_q [NUM_REGS];
    logic [DATA_W-1:0]   active_q [NUM_REGS];
    logic [NUM_REGS-1:0] hit_c;
    logic                wr_acc_c;
    logic                commit_c;

    // Address decode; indices at or above NUM_REGS never hit.
    always_comb begin
        hit_c = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (wr_en && (wr_addr == ADDR_W'(i))) begin
                hit_c[i] = 1'b1;
            end
        end
    end

    assign wr_acc_c = (|hit_c) && (|wr_byteena);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A write on the commit edge keeps the bank dirty so it goes out next frame.
    always_comb begin
        state_d  = state_q;
        commit_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_acc_c) begin
                    state_d = DIRTY;
                end
            end
            DIRTY: begin
                if (vblank_start) begin
                    if (cpu_wr_busy) begin
                        state_d = DEFER;
                    end else begin
                        commit_c = 1'b1;
                        state_d  = wr_acc_c ? DIRTY : IDLE;
                    end
                end
            end
            DEFER: begin
                if (!cpu_wr_busy) begin
                    commit_c = 1'b1;
                    state_d  = wr_acc_c ? DIRTY : IDLE;
                end else if (vblank_end_soon) begin
                    state_d = DIRTY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= RESET_VAL;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                for (int unsigned b = 0; b < NUM_BYTES; b++) begin
                    if (hit_c[i] && wr_byteena[b]) begin
                        shadow_q[i][b*8 +: 8] <= wr_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Atomic load of the whole bank; sees shadow as it was before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                active_q[i] <= RESET_VAL;
            end
        end else if (commit_c) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                active_q[i] <= shadow_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= 1'b0;
            commit_done <= 1'b0;
        end else begin
            pending     <= (state_d != IDLE);
            commit_done <= commit_c;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_active
        assign active_regs[g*DATA_W +: DATA_W] = active_q[g];
    end

`ifdef PPU_SHADOW_MISS_CNT_EN
    logic [7:0] miss_q;
    logic       abandon_c;

    assign abandon_c = (state_q == DEFER) && cpu_wr_busy && vblank_end_soon;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_q <= 8'd0;
        end else if (abandon_c && (miss_q != 8'hFF)) begin
            miss_q <= miss_q + 8'd1;
        end
    end

    assign commit_miss_cnt = miss_q;
`else
    assign commit_miss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_ppu_shadow_regs.sv
// Directed bench for ppu_shadow_regs (NUM_REGS=3 so address 3 is out of range).
module tb_ppu_shadow_regs;

    localparam int unsigned NUM_REGS = 3;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 2;

`ifdef PPU_SHADOW_MISS_CNT_EN
    localparam logic [7:0] MISS_SAT = 8'd255;
`else
    localparam logic [7:0] MISS_SAT = 8'd0;
`endif

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       wr_en;
    logic [ADDR_W-1:0]          wr_addr;
    logic [DATA_W-1:0]          wr_data;
    logic [DATA_W/8-1:0]        wr_byteena;
    logic                       cpu_wr_busy;
    logic                       vblank_start;
    logic                       vblank_end_soon;
    logic [NUM_REGS*DATA_W-1:0] active_regs;
    logic                       pending;
    logic                       commit_done;
    logic [7:0]                 commit_miss_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] exp_act [NUM_REGS];

    ppu_shadow_regs #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .RESET_VAL(32'h0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_byteena     (wr_byteena),
        .cpu_wr_busy    (cpu_wr_busy),
        .vblank_start   (vblank_start),
        .vblank_end_soon(vblank_end_soon),
        .active_regs    (active_regs),
        .pending        (pending),
        .commit_done    (commit_done),
        .commit_miss_cnt(commit_miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_active(input string tag);
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            check($sformatf("%s_reg%0d", tag, i), 128'(active_regs[i*DATA_W +: DATA_W]), 128'(exp_act[i]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_byteena = be;
        tick();
        wr_en = 1'b0; wr_byteena = '0;
    endtask

    task automatic vbs();
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_byteena = '0;
        cpu_wr_busy = 1'b0; vblank_start = 1'b0; vblank_end_soon = 1'b0;
        for (int i = 0; i < int'(NUM_REGS); i++) exp_act[i] = 32'h0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset then idle
        check_active("rst");
        check("rst_pending", 128'(pending), 128'(1'b0));
        check("rst_done", 128'(commit_done), 128'(1'b0));
        check("rst_miss", 128'(commit_miss_cnt), 128'(8'd0));
        vbs();
        check("idle_vbs_done", 128'(commit_done), 128'(1'b0));
        check("idle_vbs_pending", 128'(pending), 128'(1'b0));

        // Basic commit
        write(2'd1, 32'hDEADBEEF, 4'hF);
        check("basic_pending_set", 128'(pending), 128'(1'b1));
        vbs();
        exp_act[1] = 32'hDEADBEEF;
        check("basic_done", 128'(commit_done), 128'(1'b1));
        check_active("basic");
        check("basic_pending_clr", 128'(pending), 128'(1'b0));
        tick();
        check("basic_done_pulse", 128'(commit_done), 128'(1'b0));

        // Out-of-range and zero-byteena writes are ignored
        write(2'd3, 32'hFFFFFFFF, 4'hF);
        check("oor_pending", 128'(pending), 128'(1'b0));
        write(2'd2, 32'hFFFFFFFF, 4'h0);
        check("be0_pending", 128'(pending), 128'(1'b0));
        write(2'd0, 32'h11223344, 4'b0101);
        write(2'd3, 32'hFFFFFFFF, 4'hF);
        vbs();
        exp_act[0] = 32'h00220044;
        check("be_done", 128'(commit_done), 128'(1'b1));
        check_active("be");
        tick();

        // Deferred commit: busy falls 5 cycles after vblank_start
        write(2'd0, 32'hA5A5A5A5, 4'hF);
        cpu_wr_busy = 1'b1;
        vbs();
        check("defer_no_done", 128'(commit_done), 128'(1'b0));
        check("defer_pending", 128'(pending), 128'(1'b1));
        repeat (4) tick();
        check("defer_hold_done", 128'(commit_done), 128'(1'b0));
        check_active("defer_hold");
        cpu_wr_busy = 1'b0;
        tick();
        exp_act[0] = 32'hA5A5A5A5;
        check("defer_done", 128'(commit_done), 128'(1'b1));
        check_active("defer");
        check("defer_miss", 128'(commit_miss_cnt), 128'(8'd0));
        check("defer_pending_clr", 128'(pending), 128'(1'b0));
        tick();
        check("defer_done_pulse", 128'(commit_done), 128'(1'b0));

        // Busy drops in the same cycle as vblank_end_soon: commit wins
        write(2'd2, 32'h0000BEEF, 4'h3);
        cpu_wr_busy = 1'b1;
        vbs();
        cpu_wr_busy = 1'b0; vblank_end_soon = 1'b1;
        tick();
        vblank_end_soon = 1'b0;
        exp_act[2] = 32'h0000BEEF;
        check("race_done", 128'(commit_done), 128'(1'b1));
        check_active("race");
        check("race_miss", 128'(commit_miss_cnt), 128'(8'd0));
        tick();

        // Abandon for 260 frames, counter saturates
        write(2'd1, 32'h12345678, 4'hF);
        cpu_wr_busy = 1'b1;
        for (int f = 0; f < 260; f++) begin
            vbs();
            tick();
            vblank_end_soon = 1'b1;
            tick();
            vblank_end_soon = 1'b0;
            tick();
            if (f == 0) begin
                check("abandon_first_miss", 128'(commit_miss_cnt), 128'(MISS_SAT == 8'd0 ? 8'd0 : 8'd1));
                check("abandon_first_done", 128'(commit_done), 128'(1'b0));
            end
        end
        check_active("abandon");
        check("abandon_pending", 128'(pending), 128'(1'b1));
        check("abandon_miss_sat", 128'(commit_miss_cnt), 128'(MISS_SAT));
        cpu_wr_busy = 1'b0;
        vbs();
        exp_act[1] = 32'h12345678;
        check("recover_done", 128'(commit_done), 128'(1'b1));
        check_active("recover");
        check("recover_pending", 128'(pending), 128'(1'b0));
        check("recover_miss", 128'(commit_miss_cnt), 128'(MISS_SAT));
        tick();

        // Write coinciding with the commit edge lands in shadow only
        write(2'd2, 32'h4, 4'hF);
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 32'h5; wr_byteena = 4'hF;
        vblank_start = 1'b1;
        tick();
        wr_en = 1'b0; wr_byteena = '0; vblank_start = 1'b0;
        exp_act[2] = 32'h4;
        check("coinc_done", 128'(commit_done), 128'(1'b1));
        check_active("coinc");
        check("coinc_pending", 128'(pending), 128'(1'b1));
        tick();
        vbs();
        exp_act[2] = 32'h5;
        check("coinc_next_done", 128'(commit_done), 128'(1'b1));
        check_active("coinc_next");
        check("coinc_next_pending", 128'(pending), 128'(1'b0));
        tick();

        // Reset mid-DEFER clears everything without a commit
        write(2'd0, 32'hCAFEF00D, 4'hF);
        cpu_wr_busy = 1'b1;
        vbs();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < int'(NUM_REGS); i++) exp_act[i] = 32'h0;
        check_active("rst_defer");
        check("rst_defer_pending", 128'(pending), 128'(1'b0));
        check("rst_defer_miss", 128'(commit_miss_cnt), 128'(8'd0));
        cpu_wr_busy = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_defer_done", 128'(commit_done), 128'(1'b0));
        check_active("rst_defer_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
